// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the front-panel sequencer.
// The FSM state enum, the command enum (in priority order), the bus widths,
// the control-switch vector layout and the edge-priority resolver.
package fp_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      RST_HOLD
   } fp_state_e;

   // Listed from highest to lowest priority after CMD_NONE
   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_RESET,
      CMD_CLEAR,
      CMD_EXAMINE,
      CMD_EXAMINE_NEXT,
      CMD_DEPOSIT,
      CMD_DEPOSIT_NEXT,
      CMD_STEP
   } fp_cmd_e;

   // Bit positions of the control switches in the debounced vectors
   localparam int unsigned SW_ON_OFF       = 0;
   localparam int unsigned SW_STOP_RUN     = 1;
   localparam int unsigned SW_STEP         = 2;
   localparam int unsigned SW_EXAMINE      = 3;
   localparam int unsigned SW_EXAMINE_NEXT = 4;
   localparam int unsigned SW_DEPOSIT      = 5;
   localparam int unsigned SW_DEPOSIT_NEXT = 6;
   localparam int unsigned SW_RESET        = 7;
   localparam int unsigned SW_CLEAR        = 8;
   localparam int unsigned SW_PROTECT      = 9;
   localparam int unsigned SW_UNPROTECT    = 10;
   localparam int unsigned NUM_SW          = 11;

   // Same-cycle edges collapse to the single highest-priority command
   function automatic fp_cmd_e pick_cmd(input logic rst, input logic clr,
                                        input logic ex, input logic exn,
                                        input logic dep, input logic depn,
                                        input logic stp);
      fp_cmd_e c;
      if (rst)       c = CMD_RESET;
      else if (clr)  c = CMD_CLEAR;
      else if (ex)   c = CMD_EXAMINE;
      else if (exn)  c = CMD_EXAMINE_NEXT;
      else if (dep)  c = CMD_DEPOSIT;
      else if (depn) c = CMD_DEPOSIT_NEXT;
      else if (stp)  c = CMD_STEP;
      else           c = CMD_NONE;
      return c;
   endfunction

endpackage

// File: rtl/fp_debounce.sv
// fp_debounce: accepts a new switch level only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current debounced level, and
// flags the 0->1 acceptance with a one-cycle rise pulse.
module fp_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic level,
   output logic rise
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CW-1:0] cnt;

   // Count differing samples; any sample matching the level restarts the count
   always_ff @(posedge clk) begin
      if (reset) begin
         level <= 1'b0;
         rise  <= 1'b0;
         cnt   <= '0;
      end else begin
         rise <= 1'b0;
         if (sw == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sw;
            rise  <= sw;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/front_panel_sequencer.sv
// front_panel_sequencer: turns debounced front-panel switch edges into
// examine/deposit memory transactions, CPU step/reset/clear pulses and the
// run level. Optional build macro FRONT_PANEL_PROTECT_EN enables the
// protect/unprotect switches, which block deposits while PROT=1.
module front_panel_sequencer
   import fp_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES    = 16,
   parameter int unsigned RESET_PULSE_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              on_off_sw,
   input  logic              stop_run_sw,
   input  logic              step_sw,
   input  logic              examine_sw,
   input  logic              examine_next_sw,
   input  logic              deposit_sw,
   input  logic              deposit_next_sw,
   input  logic              reset_sw,
   input  logic              clear_sw,
   input  logic              protect_sw,
   input  logic              unprotect_sw,
   input  logic [0:7]        sense_addr_sw,
   input  logic [0:7]        data_addr_sw,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_run,
   output logic              cpu_step,
   output logic              cpu_reset,
   output logic              clear_pulse,
   output logic [ADDR_W-1:0] panel_addr,
   output logic [DATA_W-1:0] panel_data,
   output logic              PROT
);

   localparam int unsigned RCW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;

   fp_state_e         state, state_n;
   fp_cmd_e           cmd;
   logic [NUM_SW-1:0] sw_raw, sw_lvl, sw_rise;
   logic              on_off, take_reset, wr_blocked, rst_pend, rst_pend_n;
   logic              mem_req_n, mem_we_n, cpu_step_n, clear_pulse_n, prot_n;
   logic [ADDR_W-1:0] mem_addr_n, panel_addr_n, addr_inc, sw_addr;
   logic [DATA_W-1:0] mem_wdata_n, panel_data_n;
   logic [RCW-1:0]    rst_cnt, rst_cnt_n;
   logic              unused_sw;

   assign sw_raw = {unprotect_sw, protect_sw, clear_sw, reset_sw, deposit_next_sw,
                    deposit_sw, examine_next_sw, examine_sw, step_sw, stop_run_sw, on_off_sw};

   for (genvar i = 0; i < NUM_SW; i++) begin : g_db
      fp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .reset (reset),
         .sw    (sw_raw[i]),
         .level (sw_lvl[i]),
         .rise  (sw_rise[i])
      );
   end

   // Debounced levels and edges that nothing here consumes
   assign unused_sw = ^{sw_lvl[NUM_SW-1:SW_STEP], sw_rise[SW_STOP_RUN:SW_ON_OFF],
                        sw_rise[SW_UNPROTECT:SW_PROTECT]};

   assign on_off     = sw_lvl[SW_ON_OFF];
   assign cpu_run    = sw_lvl[SW_STOP_RUN] && !on_off && (state != RST_HOLD);
   assign cpu_reset  = (state == RST_HOLD);
   assign wr_blocked = PROT;
   assign addr_inc   = panel_addr + ADDR_W'(1);
   assign sw_addr    = {sense_addr_sw, data_addr_sw};
   assign cmd        = pick_cmd(sw_rise[SW_RESET], sw_rise[SW_CLEAR], sw_rise[SW_EXAMINE],
                                sw_rise[SW_EXAMINE_NEXT], sw_rise[SW_DEPOSIT],
                                sw_rise[SW_DEPOSIT_NEXT], sw_rise[SW_STEP]);
   assign take_reset = (cmd == CMD_RESET) && !on_off;

   // Next-state and next-output logic for the sequencer
   always_comb begin
      state_n       = state;
      mem_req_n     = mem_req;
      mem_we_n      = mem_we;
      mem_addr_n    = mem_addr;
      mem_wdata_n   = mem_wdata;
      panel_addr_n  = panel_addr;
      panel_data_n  = panel_data;
      rst_pend_n    = rst_pend;
      rst_cnt_n     = rst_cnt;
      cpu_step_n    = 1'b0;
      clear_pulse_n = (cmd == CMD_CLEAR) && !on_off;
      prot_n        = PROT;
`ifdef FRONT_PANEL_PROTECT_EN
      if (!on_off) begin
         if (sw_rise[SW_PROTECT])        prot_n = 1'b1;
         else if (sw_rise[SW_UNPROTECT]) prot_n = 1'b0;
      end
`else
      prot_n = 1'b0;
`endif
      if (on_off && (state == IDLE || state == RST_HOLD)) begin
         // Powered off with nothing in flight: hold every output at its reset value
         state_n      = IDLE;
         mem_req_n    = 1'b0;
         mem_we_n     = 1'b0;
         mem_addr_n   = '0;
         mem_wdata_n  = '0;
         panel_addr_n = '0;
         panel_data_n = '0;
         rst_pend_n   = 1'b0;
         prot_n       = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               case (cmd)
                  CMD_RESET: begin
                     state_n      = RST_HOLD;
                     panel_addr_n = '0;
                     rst_cnt_n    = RCW'(RESET_PULSE_CYCLES - 1);
                  end
                  CMD_EXAMINE, CMD_EXAMINE_NEXT: if (!cpu_run) begin
                     panel_addr_n = (cmd == CMD_EXAMINE) ? sw_addr : addr_inc;
                     mem_addr_n   = panel_addr_n;
                     mem_we_n     = 1'b0;
                     mem_req_n    = 1'b1;
                     state_n      = RD_REQ;
                  end
                  CMD_DEPOSIT, CMD_DEPOSIT_NEXT: if (!cpu_run) begin
                     if (cmd == CMD_DEPOSIT_NEXT) panel_addr_n = addr_inc;
                     if (!wr_blocked) begin
                        mem_addr_n  = panel_addr_n;
                        mem_wdata_n = data_addr_sw;
                        mem_we_n    = 1'b1;
                        mem_req_n   = 1'b1;
                        state_n     = WR_REQ;
                     end
                  end
                  CMD_STEP: cpu_step_n = !cpu_run;
                  default: ;
               endcase
            end
            RD_REQ, RD_WAIT, WR_REQ, WR_WAIT: begin
               // A reset_sw edge seen while the bus is busy waits for the ack
               if (take_reset) rst_pend_n = 1'b1;
               if (mem_ack) begin
                  mem_req_n    = 1'b0;
                  mem_we_n     = 1'b0;
                  panel_data_n = mem_we ? mem_wdata : mem_rdata;
                  rst_pend_n   = 1'b0;
                  if ((rst_pend || take_reset) && !on_off) begin
                     state_n      = RST_HOLD;
                     panel_addr_n = '0;
                     rst_cnt_n    = RCW'(RESET_PULSE_CYCLES - 1);
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  state_n = (state == RD_REQ || state == RD_WAIT) ? RD_WAIT : WR_WAIT;
               end
            end
            RST_HOLD: begin
               if (rst_cnt == '0) state_n = IDLE;
               else rst_cnt_n = rst_cnt - RCW'(1);
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         panel_addr  <= '0;
         panel_data  <= '0;
         rst_pend    <= 1'b0;
         rst_cnt     <= '0;
         cpu_step    <= 1'b0;
         clear_pulse <= 1'b0;
         PROT        <= 1'b0;
      end else begin
         state       <= state_n;
         mem_req     <= mem_req_n;
         mem_we      <= mem_we_n;
         mem_addr    <= mem_addr_n;
         mem_wdata   <= mem_wdata_n;
         panel_addr  <= panel_addr_n;
         panel_data  <= panel_data_n;
         rst_pend    <= rst_pend_n;
         rst_cnt     <= rst_cnt_n;
         cpu_step    <= cpu_step_n;
         clear_pulse <= clear_pulse_n;
         PROT        <= prot_n;
      end
   end

endmodule

// File: tb/tb_front_panel_sequencer.sv
// tb_front_panel_sequencer: scoreboard bench for the front-panel sequencer.
// Expected memory transactions are queued when a switch is pressed and
// popped when the DUT raises mem_req.
module tb_front_panel_sequencer;

   localparam int unsigned DB = 4;
   localparam int unsigned RP = 8;

   localparam logic [10:0] M_ONOFF = 11'h001, M_STOP = 11'h002, M_STEP = 11'h004,
                           M_EXAM  = 11'h008, M_EXMN = 11'h010, M_DEP  = 11'h020,
                           M_DEPN  = 11'h040, M_RST  = 11'h080, M_CLR  = 11'h100,
                           M_PROT  = 11'h200, M_UNPR = 11'h400;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } txn_t;

   logic        clk = 1'b0, reset = 1'b1;
   logic [10:0] sw = '0;
   logic [7:0]  sense = '0, data = '0, mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        mem_req, mem_we, cpu_run, cpu_step, cpu_reset, clear_pulse, PROT;
   logic [15:0] mem_addr, panel_addr;
   logic [7:0]  mem_wdata, panel_data;

   txn_t        exp_q[$];
   txn_t        cur;
   int unsigned n_checks = 0, n_fail = 0;
   int unsigned step_cnt = 0, req_cnt = 0;
   logic        req_q = 1'b0;

   front_panel_sequencer #(.DEBOUNCE_CYCLES(DB), .RESET_PULSE_CYCLES(RP)) dut (
      .clk(clk), .reset(reset),
      .on_off_sw(sw[0]), .stop_run_sw(sw[1]), .step_sw(sw[2]), .examine_sw(sw[3]),
      .examine_next_sw(sw[4]), .deposit_sw(sw[5]), .deposit_next_sw(sw[6]),
      .reset_sw(sw[7]), .clear_sw(sw[8]), .protect_sw(sw[9]), .unprotect_sw(sw[10]),
      .sense_addr_sw(sense), .data_addr_sw(data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .cpu_run(cpu_run), .cpu_step(cpu_step), .cpu_reset(cpu_reset),
      .clear_pulse(clear_pulse), .panel_addr(panel_addr), .panel_data(panel_data),
      .PROT(PROT)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cpu_step) step_cnt <= step_cnt + 1;
      if (mem_req && !req_q) req_cnt <= req_cnt + 1;
      req_q <= mem_req;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic press(input logic [10:0] m);
      @(negedge clk) sw = sw | m;
      repeat (DB) @(negedge clk);
   endtask

   task automatic release_sw(input logic [10:0] m);
      sw = sw & ~m;
      repeat (DB + 1) @(negedge clk);
   endtask

   task automatic serve_start();
      int unsigned n = 0;
      while (!mem_req && n < 12) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", mem_req, 1);
      if (mem_req) begin
         check("req_latency", n, 1);
         check("sb_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("mem_we", mem_we, cur.we);
            check("mem_addr", mem_addr, cur.addr);
            if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
         end
      end
   endtask

   task automatic serve_finish(input logic [7:0] rd, input int unsigned hold, input logic [7:0] exp_pd);
      repeat (hold) begin
         @(negedge clk);
         check("req_hold", {mem_req, mem_we, mem_addr}, {1'b1, cur.we, cur.addr});
      end
      mem_rdata = rd;
      mem_ack   = 1'b1;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check("req_drop", mem_req, 0);
      check("panel_data", panel_data, exp_pd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned s0, r0, n;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_panel_addr", panel_addr, 0);
      check("rst_panel_data", panel_data, 0);
      check("rst_outs", {cpu_run, cpu_step, cpu_reset, clear_pulse, PROT}, 0);

      // Examine 0x1234, read returns 0xA5
      sense = 8'h12; data = 8'h34;
      exp_q.push_back('{1'b0, 16'h1234, 8'h00});
      press(M_EXAM);
      serve_start();
      serve_finish(8'hA5, 2, 8'hA5);
      check("ex_panel_addr", panel_addr, 16'h1234);
      release_sw(M_EXAM);

      // Examine 0xFFFF then examine_next wraps to 0x0000
      sense = 8'hFF; data = 8'hFF;
      exp_q.push_back('{1'b0, 16'hFFFF, 8'h00});
      press(M_EXAM);
      serve_start();
      serve_finish(8'h3C, 1, 8'h3C);
      release_sw(M_EXAM);
      exp_q.push_back('{1'b0, 16'h0000, 8'h00});
      press(M_EXMN);
      serve_start();
      serve_finish(8'h5A, 0, 8'h5A);
      check("exn_wrap_addr", panel_addr, 16'h0000);
      release_sw(M_EXMN);

      // Deposit_next from 0x0100 writes 0x5C to 0x0101
      sense = 8'h01; data = 8'h00;
      exp_q.push_back('{1'b0, 16'h0100, 8'h00});
      press(M_EXAM);
      serve_start();
      serve_finish(8'h99, 0, 8'h99);
      release_sw(M_EXAM);
      data = 8'h5C;
      exp_q.push_back('{1'b1, 16'h0101, 8'h5C});
      press(M_DEPN);
      serve_start();
      serve_finish(8'hEE, 1, 8'h5C);
      check("depn_panel_addr", panel_addr, 16'h0101);
      release_sw(M_DEPN);

      // Deposit and step together: only the write happens
      data = 8'h77;
      s0 = step_cnt;
      exp_q.push_back('{1'b1, 16'h0101, 8'h77});
      press(M_DEP | M_STEP);
      serve_start();
      serve_finish(8'h00, 1, 8'h77);
      repeat (2) @(negedge clk);
      check("dep_step_nostep", step_cnt - s0, 0);
      release_sw(M_DEP | M_STEP);

      // Step alone: one-cycle pulse, no memory traffic
      r0 = req_cnt;
      press(M_STEP);
      @(negedge clk);
      check("step_hi", cpu_step, 1);
      @(negedge clk);
      check("step_lo", cpu_step, 0);
      check("step_noreq", req_cnt - r0, 0);
      release_sw(M_STEP);

      // Clear: one-cycle pulse
      press(M_CLR);
      @(negedge clk);
      check("clear_hi", clear_pulse, 1);
      @(negedge clk);
      check("clear_lo", clear_pulse, 0);
      release_sw(M_CLR);

      // Running CPU blocks examine
      press(M_STOP);
      check("run_level", cpu_run, 1);
      r0 = req_cnt;
      press(M_EXAM);
      repeat (6) @(negedge clk);
      check("run_blocks_exam", req_cnt - r0, 0);
      release_sw(M_EXAM);
      release_sw(M_STOP);
      check("run_off", cpu_run, 0);

      // Glitch one cycle short of the debounce window
      r0 = req_cnt;
      @(negedge clk) sw = sw | M_EXAM;
      repeat (DB - 1) @(negedge clk);
      sw = sw & ~M_EXAM;
      repeat (DB + 4) @(negedge clk);
      check("glitch_noreq", req_cnt - r0, 0);

      // Power switch off: panel cleared, step ignored
      press(M_ONOFF);
      @(negedge clk);
      check("off_panel_addr", panel_addr, 0);
      check("off_panel_data", panel_data, 0);
      s0 = step_cnt;
      press(M_STEP);
      repeat (3) @(negedge clk);
      check("off_nostep", step_cnt - s0, 0);
      release_sw(M_STEP | M_ONOFF);

      // reset_sw during RD_WAIT is held until the ack
      sense = 8'hAB; data = 8'hCD;
      exp_q.push_back('{1'b0, 16'hABCD, 8'h00});
      press(M_EXAM);
      serve_start();
      press(M_RST);
      repeat (2) @(negedge clk);
      check("pend_no_cpu_reset", cpu_reset, 0);
      check("pend_req_held", mem_req, 1);
      serve_finish(8'hC3, 0, 8'hC3);
      check("rsthold_panel_addr", panel_addr, 0);
      n = 0;
      while (cpu_reset && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("cpu_reset_width", n, RP);
      release_sw(M_EXAM | M_RST);

      // Reset in WR_WAIT drops mem_req; late ack ignored
      data = 8'h42;
      exp_q.push_back('{1'b1, 16'h0000, 8'h42});
      press(M_DEP);
      serve_start();
      @(negedge clk);
      reset = 1'b1;
      sw = sw & ~M_DEP;
      @(negedge clk);
      check("rst_mid_wr_req", mem_req, 0);
      reset = 1'b0;
      mem_rdata = 8'h66;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("late_ack_req", mem_req, 0);
      check("late_ack_data", panel_data, 0);
      repeat (DB + 2) @(negedge clk);

`ifdef FRONT_PANEL_PROTECT_EN
      // Protected deposit_next moves the address but issues no write
      press(M_PROT);
      @(negedge clk);
      check("prot_set", PROT, 1);
      data = 8'h11;
      r0 = req_cnt;
      press(M_DEPN);
      repeat (4) @(negedge clk);
      check("prot_noreq", req_cnt - r0, 0);
      check("prot_panel_addr", panel_addr, 16'h0001);
      release_sw(M_DEPN | M_PROT);
      press(M_UNPR);
      @(negedge clk);
      check("prot_clear", PROT, 0);
      release_sw(M_UNPR);
`endif

      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
